sd_cmd_engine: RTL
==================

Name: sd_cmd_engine

Overview:
- Parametrised successor to the SD command generator. Issues one SPI-mode SD command frame with a hardware-computed CRC7.
- Collects a response of selectable format: R1, R1+32-bit (R3/R7), R1b busy-wait, or R1 followed by a single data block read.
- Sits between the SD card controller FSM and spi_master_cpol0_cpha0, driving the master's byte handshake and the card chip select.

Parameters:
- RESP_TIMEOUT, 8, maximum 0xFF poll bytes while waiting for R1 (MSB=0).
- BUSY_TIMEOUT, 65535, maximum poll bytes in R1b busy-wait.
- TOKEN_TIMEOUT, 4095, maximum poll bytes while waiting for the 0xFE data token.
- BLOCK_LEN, 512, data bytes per block read.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- cmd  input  6  command index, sampled on go
- arg  input  32  command argument, sampled on go
- mode  input  2  sampled on go; 0=R1, 1=R1+4 bytes, 2=R1b, 3=R1+data block
- go  input  1  start pulse, honoured only when busy=0
- busy  output  1  high from the cycle after an accepted go until done
- done  output  1  one-cycle completion pulse
- resp_r1  output  8  R1 byte (0xFF on timeout)
- resp_ext  output  32  trailing R3/R7 bytes, MSB first
- err  output  3  bit0 R1 timeout, bit1 busy/token timeout, bit2 data error token
- data_out  output  8  block data byte
- data_valid  output  1  one-cycle strobe per block byte
- data_crc  output  16  received block CRC16, not checked
- spi_go  output  1  one-cycle byte-transfer request to the SPI master
- spi_tx_data  output  8  byte to transmit, stable from spi_go until spi_done
- spi_rx_data  input  8  received byte, valid in the spi_done cycle
- spi_done  input  1  one-cycle byte-complete pulse
- spi_cs  output  1  card select, active-low

Behaviour:
- Reset (rst=0 at a clk edge) values:
  - busy=0, done=0, resp_r1=0xFF, resp_ext=0, err=0.
  - data_out=0, data_valid=0, data_crc=0.
  - spi_go=0, spi_tx_data=0xFF, spi_cs=1, FSM=IDLE.
  - Reset mid-operation aborts immediately, without a trailing byte. The SPI master shares this reset.
- Byte handshake:
  - Every byte is spi_go pulse -> wait spi_done.
  - The next spi_go is asserted no earlier than the cycle after spi_done.
  - At most one byte is outstanding.
- States:
  - IDLE: on go with busy=0, latch cmd/arg/mode, clear err, drive spi_cs=0 → PRE.
  - PRE: send 0xFF → CMD.
  - CMD: send 6 bytes: {2'b01,cmd}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc7,1'b1}.
    - crc7 uses polynomial x^7+x^3+1 over the first 5 bytes, computed bit-serially or per byte before byte 6 is issued.
  - R1POLL: send 0xFF.
    - Accept the first rx byte with bit7=0 into resp_r1.
    - After RESP_TIMEOUT bytes without a match: err[0]=1, resp_r1=0xFF → TRAIL.
    - On match: mode 0 → TRAIL, 1 → EXT, 2 → BUSYW, 3 → TOKEN if resp_r1==0x00, else TRAIL.
  - EXT: 4 bytes shifted into resp_ext MSB first → TRAIL.
  - BUSYW: poll until rx != 0x00. Timeout → err[1] → TRAIL.
  - TOKEN: poll.
    - 0xFF → keep polling.
    - 0xFE → DATA.
    - Any other byte → err[2]=1, resp_ext[7:0]=byte → TRAIL.
    - Timeout → err[1] → TRAIL.
  - DATA: BLOCK_LEN bytes. Each spi_done cycle gives data_valid=1 with data_out=rx byte, registered, one cycle later → CRC.
  - CRC: 2 bytes into data_crc, MSB first → TRAIL.
  - TRAIL: send one 0xFF with spi_cs still 0, then spi_cs=1, done=1 for one cycle, busy=0 → IDLE.
- Timeout and byte counters are wide enough for the largest parameter. A counter equal to its limit triggers the timeout; there is no wrap-around.
- go while busy=1 is ignored. go in the same cycle as done is ignored; a new go is honoured from the following cycle.
- resp_r1, resp_ext, err and data_crc hold their values until the next accepted go.

Test Plan:
- CMD0, arg=0, mode 0, card returns 0x01 on the 2nd poll → MOSI bytes FF 40 00 00 00 00 95 FF FF FF; resp_r1=0x01; err=0; single done pulse; spi_cs low only between the first and last bytes.
- CMD8, arg=0x1AA, mode 1, card returns 01 00 00 01 AA → CRC byte 0x87; resp_r1=0x01; resp_ext=0x000001AA.
- CMD17, mode 3, RESP_TIMEOUT=8, BLOCK_LEN=4:
  - R1=0x00, three 0xFF then 0xFE, data 11 22 33 44, CRC AB CD → four data_valid strobes carrying 11,22,33,44; data_crc=0xABCD.
  - R1=0x00, token 0x05 → err=3'b100.
- MISO held 0xFF, mode 0 → exactly 8 poll bytes; err=3'b001; resp_r1=0xFF; done.
- Mode 2, MISO 0x00 for 20 bytes then 0xFF → done after busy release with err=0. Second go pulsed while busy → no effect.
- rst driven low during DATA → next cycle spi_cs=1, busy=0. A fresh CMD0 afterwards completes normally.

Source files
------------

// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SPI-mode SD command engine: CRC7 framed command, R1/R3/R7/R1b/block-read response
module sd_cmd_engine #(
    parameter int RESP_TIMEOUT  = 8,
    parameter int BUSY_TIMEOUT  = 65535,
    parameter int TOKEN_TIMEOUT = 4095,
    parameter int BLOCK_LEN     = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  cmd,
    input  logic [31:0] arg,
    input  logic [1:0]  mode,
    input  logic        go,
    output logic        busy,
    output logic        done,
    output logic [7:0]  resp_r1,
    output logic [31:0] resp_ext,
    output logic [2:0]  err,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [15:0] data_crc,
    output logic        spi_go,
    output logic [7:0]  spi_tx_data,
    input  logic [7:0]  spi_rx_data,
    input  logic        spi_done,
    output logic        spi_cs
);

    localparam int MAX_AB  = (RESP_TIMEOUT > BUSY_TIMEOUT) ? RESP_TIMEOUT : BUSY_TIMEOUT;
    localparam int MAX_CD  = (TOKEN_TIMEOUT > BLOCK_LEN) ? TOKEN_TIMEOUT : BLOCK_LEN;
    localparam int MAX_LIM = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = ($clog2(MAX_LIM + 1) > 3) ? $clog2(MAX_LIM + 1) : 3;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_CMD, S_R1POLL, S_EXT, S_BUSYW, S_TOKEN, S_DATA, S_CRC, S_TRAIL
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         cmd_q, cmd_d;
    logic [31:0]        arg_q, arg_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [6:0]         crc7_q, crc7_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         resp_r1_q, resp_r1_d;
    logic [31:0]        resp_ext_q, resp_ext_d;
    logic [2:0]         err_q, err_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic [15:0]        data_crc_q, data_crc_d;
    logic               spi_go_q, spi_go_d;
    logic [7:0]         tx_q, tx_d;
    logic               cs_q, cs_d;
    logic [7:0]         cmd_byte;
    logic [CNT_W-1:0]   cnt_inc;

    // Bit-serial CRC7 (x^7 + x^3 + 1), MSB first, folded over one byte per call
    function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] b);
        logic [6:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = b[i] ^ r[6];
            r  = {r[5:0], 1'b0};
            if (fb) r = r ^ 7'h09;
        end
        return r;
    endfunction

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        cmd_byte = 8'hFF;
        case (cnt_q[2:0])
            3'd0:    cmd_byte = {2'b01, cmd_q};
            3'd1:    cmd_byte = arg_q[31:24];
            3'd2:    cmd_byte = arg_q[23:16];
            3'd3:    cmd_byte = arg_q[15:8];
            3'd4:    cmd_byte = arg_q[7:0];
            3'd5:    cmd_byte = {crc7_q, 1'b1};
            default: cmd_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        arg_d        = arg_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        crc7_d       = crc7_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        resp_r1_d    = resp_r1_q;
        resp_ext_d   = resp_ext_q;
        err_d        = err_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        data_crc_d   = data_crc_q;
        spi_go_d     = 1'b0;
        tx_d         = tx_q;
        cs_d         = cs_q;

        if (state_q == S_IDLE) begin
            // done_q blocks a go that arrives in the completion cycle
            if (go && !done_q) begin
                cmd_d      = cmd;
                arg_d      = arg;
                mode_d     = mode;
                err_d      = 3'b000;
                resp_r1_d  = 8'hFF;
                resp_ext_d = 32'h0;
                data_crc_d = 16'h0;
                crc7_d     = 7'h00;
                cnt_d      = '0;
                pend_d     = 1'b0;
                busy_d     = 1'b1;
                cs_d       = 1'b0;
                state_d    = S_PRE;
            end
        end else if (!pend_q) begin
            spi_go_d = 1'b1;
            pend_d   = 1'b1;
            tx_d     = (state_q == S_CMD) ? cmd_byte : 8'hFF;
            if (state_q == S_CMD && cnt_q[2:0] < 3'd5) crc7_d = crc7_byte(crc7_q, cmd_byte);
        end else if (spi_done) begin
            pend_d = 1'b0;
            cnt_d  = cnt_inc;
            case (state_q)
                S_PRE: begin
                    cnt_d   = '0;
                    state_d = S_CMD;
                end
                S_CMD: begin
                    if (cnt_q[2:0] == 3'd5) begin
                        cnt_d   = '0;
                        state_d = S_R1POLL;
                    end
                end
                S_R1POLL: begin
                    if (!spi_rx_data[7]) begin
                        resp_r1_d = spi_rx_data;
                        cnt_d     = '0;
                        case (mode_q)
                            2'd0:    state_d = S_TRAIL;
                            2'd1:    state_d = S_EXT;
                            2'd2:    state_d = S_BUSYW;
                            default: state_d = (spi_rx_data == 8'h00) ? S_TOKEN : S_TRAIL;
                        endcase
                    end else if (cnt_inc == CNT_W'(RESP_TIMEOUT)) begin
                        err_d[0]  = 1'b1;
                        resp_r1_d = 8'hFF;
                        state_d   = S_TRAIL;
                    end
                end
                S_EXT: begin
                    resp_ext_d = {resp_ext_q[23:0], spi_rx_data};
                    if (cnt_inc == CNT_W'(4)) state_d = S_TRAIL;
                end
                S_BUSYW: begin
                    if (spi_rx_data != 8'h00) begin
                        state_d = S_TRAIL;
                    end else if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
                        err_d[1] = 1'b1;
                        state_d  = S_TRAIL;
                    end
                end
                S_TOKEN: begin
                    if (spi_rx_data == 8'hFE) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end else if (spi_rx_data != 8'hFF) begin
                        err_d[2]         = 1'b1;
                        resp_ext_d[7:0]  = spi_rx_data;
                        state_d          = S_TRAIL;
                    end else if (cnt_inc == CNT_W'(TOKEN_TIMEOUT)) begin
                        err_d[1] = 1'b1;
                        state_d  = S_TRAIL;
                    end
                end
                S_DATA: begin
                    data_out_d   = spi_rx_data;
                    data_valid_d = 1'b1;
                    if (cnt_inc == CNT_W'(BLOCK_LEN)) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end
                end
                S_CRC: begin
                    data_crc_d = {data_crc_q[7:0], spi_rx_data};
                    if (cnt_inc == CNT_W'(2)) state_d = S_TRAIL;
                end
                S_TRAIL: begin
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cmd_q        <= 6'h0;
            arg_q        <= 32'h0;
            mode_q       <= 2'd0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            crc7_q       <= 7'h0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            resp_r1_q    <= 8'hFF;
            resp_ext_q   <= 32'h0;
            err_q        <= 3'b000;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            data_crc_q   <= 16'h0;
            spi_go_q     <= 1'b0;
            tx_q         <= 8'hFF;
            cs_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            arg_q        <= arg_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            crc7_q       <= crc7_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            resp_r1_q    <= resp_r1_d;
            resp_ext_q   <= resp_ext_d;
            err_q        <= err_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            data_crc_q   <= data_crc_d;
            spi_go_q     <= spi_go_d;
            tx_q         <= tx_d;
            cs_q         <= cs_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign resp_r1     = resp_r1_q;
    assign resp_ext    = resp_ext_q;
    assign err         = err_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign data_crc    = data_crc_q;
    assign spi_go      = spi_go_q;
    assign spi_tx_data = tx_q;
    assign spi_cs      = cs_q;

endmodule
